// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU arbiter: command layout, opcodes, FSM states.
package alsu_pkg;

  localparam int CMD_W = 16;

  // Field offsets (LSB position) inside the packed command, MSB first:
  // opcode[2:0], A[2:0], B[2:0], cin, serial_in, direction,
  // red_op_A, red_op_B, bypass_A, bypass_B.
  localparam int OFS_OPCODE = 13;
  localparam int OFS_A      = 10;
  localparam int OFS_B      = 7;
  localparam int OFS_CIN    = 6;
  localparam int OFS_SERIAL = 5;
  localparam int OFS_DIR    = 4;
  localparam int OFS_RED_A  = 3;
  localparam int OFS_RED_B  = 2;
  localparam int OFS_BYP_A  = 1;
  localparam int OFS_BYP_B  = 0;

  localparam logic [2:0] OPC_SHIFT = 3'b100;
  localparam logic [2:0] OPC_ROT   = 3'b101;
  localparam logic [2:0] OPC_INV0  = 3'b110;
  localparam logic [2:0] OPC_INV1  = 3'b111;

  // Command driven onto the ALSU whenever no command is being issued.
  localparam logic [CMD_W-1:0] IDLE_CMD = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Opcodes the ALSU does not implement; these never reach it.
  function automatic logic is_invalid_opc(input logic [2:0] opc);
    return (opc == OPC_INV0) || (opc == OPC_INV1);
  endfunction

endpackage

// File: rtl/alsu_arbiter_if.sv
// Requester handshake, response and ALSU-side signals of the ALSU arbiter.
interface alsu_arbiter_if;
  import alsu_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [CMD_W-1:0] req0_cmd;
  logic             req1_valid;
  logic             req1_ready;
  logic [CMD_W-1:0] req1_cmd;

  logic             rsp0_valid;
  logic             rsp1_valid;
  logic [5:0]       rsp_data;
  logic             rsp_err;
  logic             busy;

  logic [2:0]       alsu_opcode;
  logic [2:0]       alsu_A;
  logic [2:0]       alsu_B;
  logic             alsu_cin;
  logic             alsu_serial_in;
  logic             alsu_direction;
  logic             alsu_red_op_A;
  logic             alsu_red_op_B;
  logic             alsu_bypass_A;
  logic             alsu_bypass_B;
  logic [5:0]       alsu_out;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_cmd, req1_valid, req1_cmd, alsu_out,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err, busy,
           alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in, alsu_direction,
           alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B
  );

  // Environment side: requesters plus the ALSU itself.
  modport master (
    output req0_valid, req0_cmd, req1_valid, req1_cmd, alsu_out,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err, busy,
           alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in, alsu_direction,
           alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B
  );

endinterface

// File: rtl/alsu_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant, pointer moves past the winner on accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;  // requester favoured on a tie

  // A lone request wins outright; a tie goes to the favoured requester.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (req_i == 2'b11) gnt_o[ptr_q] = 1'b1;
    else                gnt_o = req_i;
    // Favour the requester that did not just win.
    if (accept_i) ptr_d = gnt_o[0];
  end

  // Pointer register; reset favours requester 0.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every register samples the pre-edge values of the others.
    if (!rst) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alsu_arbiter.sv
// Shares one ALSU between two requesters: accepts a command, issues it for one
// cycle, captures the result after ALSU_LAT cycles and returns it to its owner.
module alsu_arbiter
  import alsu_pkg::*;
#(
  parameter int ALSU_LAT = 2
) (
  input logic           clk,
  input logic           rst,
  alsu_arbiter_if.slave bus
);

  localparam int CNT_W = (ALSU_LAT > 1) ? $clog2(ALSU_LAT) : 1;

  state_e           state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CMD_W-1:0] alsu_cmd_q, alsu_cmd_d;
  logic [1:0]       rsp_vld_q, rsp_vld_d;
  logic [5:0]       rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q;
  logic [1:0]       req;
  logic [1:0]       gnt;

  // Requests reach the arbiter only while idle and out of reset, so a grant
  // is always an accept.
  assign req = {bus.req1_valid, bus.req0_valid} & {2{(state_q == ST_IDLE) && rst}};

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .accept_i (|gnt),
    .gnt_o    (gnt)
  );

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  // Next-state and registered-output logic of the command FSM.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    alsu_cmd_d = IDLE_CMD;
    rsp_vld_d  = 2'b00;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          owner_d = gnt[1];
          cmd_d   = gnt[1] ? bus.req1_cmd : bus.req0_cmd;
          if (is_invalid_opc(cmd_d[OFS_OPCODE +: 3])) begin
            // Rejected without touching the ALSU.
            state_d    = ST_RESP;
            rsp_vld_d  = gnt;
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end else begin
            state_d    = ST_ISSUE;
            alsu_cmd_d = cmd_d;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ALSU_LAT - 1)) begin
          state_d            = ST_RESP;
          rsp_data_d         = bus.alsu_out;
          rsp_err_d          = 1'b0;
          rsp_vld_d[owner_q] = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight command.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      alsu_cmd_q <= IDLE_CMD;
      rsp_vld_q  <= 2'b00;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      alsu_cmd_q <= alsu_cmd_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign bus.rsp0_valid     = rsp_vld_q[0];
  assign bus.rsp1_valid     = rsp_vld_q[1];
  assign bus.rsp_data       = rsp_data_q;
  assign bus.rsp_err        = rsp_err_q;
  assign bus.busy           = busy_q;

  assign bus.alsu_opcode    = alsu_cmd_q[OFS_OPCODE +: 3];
  assign bus.alsu_A         = alsu_cmd_q[OFS_A +: 3];
  assign bus.alsu_B         = alsu_cmd_q[OFS_B +: 3];
  assign bus.alsu_cin       = alsu_cmd_q[OFS_CIN];
  assign bus.alsu_serial_in = alsu_cmd_q[OFS_SERIAL];
  assign bus.alsu_direction = alsu_cmd_q[OFS_DIR];
  assign bus.alsu_red_op_A  = alsu_cmd_q[OFS_RED_A];
  assign bus.alsu_red_op_B  = alsu_cmd_q[OFS_RED_B];
  assign bus.alsu_bypass_A  = alsu_cmd_q[OFS_BYP_A];
  assign bus.alsu_bypass_B  = alsu_cmd_q[OFS_BYP_B];

endmodule

// File: tb/tb_alsu_arbiter.sv
// Bench for alsu_arbiter: a two-stage ALSU model on the ALSU pins, directed
// scenarios plus random requesters, all checked against a timeline model.
module tb_alsu_arbiter;
  import alsu_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  alsu_arbiter_if bus ();

  alsu_arbiter #(.ALSU_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ALSU function for the non-stateful opcodes.
  function automatic logic [5:0] alsu_ref(input logic [CMD_W-1:0] c);
    logic [2:0] opc, a, b;
    opc = c[OFS_OPCODE +: 3];
    a   = c[OFS_A +: 3];
    b   = c[OFS_B +: 3];
    if (c[OFS_BYP_A]) return {3'b000, a};
    if (c[OFS_BYP_B]) return {3'b000, b};
    case (opc)
      3'd0:    return c[OFS_RED_A] ? {5'd0, &a} : c[OFS_RED_B] ? {5'd0, &b} : {3'd0, a & b};
      3'd1:    return c[OFS_RED_A] ? {5'd0, ^a} : c[OFS_RED_B] ? {5'd0, ^b} : {3'd0, a ^ b};
      3'd2:    return 6'(a) + 6'(b) + 6'(c[OFS_CIN]);
      3'd3:    return 6'(a) * 6'(b);
      default: return 6'd0;
    endcase
  endfunction

  // ALSU model: samples its pins on one edge, result register valid after the next.
  logic [CMD_W-1:0] alsu_pins, alsu_stage;
  assign alsu_pins = {bus.alsu_opcode, bus.alsu_A, bus.alsu_B, bus.alsu_cin,
                      bus.alsu_serial_in, bus.alsu_direction, bus.alsu_red_op_A,
                      bus.alsu_red_op_B, bus.alsu_bypass_A, bus.alsu_bypass_B};
  always @(posedge clk) begin
    if (!rst) begin
      alsu_stage   <= '0;
      bus.alsu_out <= '0;
    end else begin
      alsu_stage   <= alsu_pins;
      bus.alsu_out <= alsu_ref(alsu_stage);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  // Timeline model: cycle numbers at which each event is due.
  int               cyc      = 0;
  bit               live     = 1'b0;
  int               free_cyc = 0;
  int               iss_cyc  = -1;
  int               rsp_cyc  = -1;
  int               zero_cyc = -1;
  int               rsp_own  = 0;
  int               last_gnt = 1;
  logic [CMD_W-1:0] iss_cmd  = '0;
  logic [5:0]       rsp_dat  = '0;
  logic             rsp_e    = 1'b0;

  // What the requesters saw in the last cycle.
  logic [1:0] obs_acc = '0;
  logic [1:0] obs_rsp = '0;
  int         obs_own[$];
  int         obs_at[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Observe one cycle at the falling edge, advance the model, then move past the rising edge.
  task automatic step();
    logic [1:0]       v, exp_gnt;
    int               own;
    logic [CMD_W-1:0] c;
    @(negedge clk);
    v       = {bus.req1_valid, bus.req0_valid};
    exp_gnt = 2'b00;
    obs_acc = rst ? (v & {bus.req1_ready, bus.req0_ready}) : 2'b00;
    obs_rsp = {bus.rsp1_valid, bus.rsp0_valid};
    if (obs_acc != 2'b00) begin
      obs_own.push_back(obs_acc[1] ? 1 : 0);
      obs_at.push_back(cyc);
    end
    if (live) begin
      if (rst && cyc >= free_cyc) exp_gnt = (v == 2'b11) ? ((last_gnt == 1) ? 2'b01 : 2'b10) : v;
      check("req0_ready", bus.req0_ready, exp_gnt[0]);
      check("req1_ready", bus.req1_ready, exp_gnt[1]);
      check("busy", bus.busy, cyc < free_cyc);
      check("alsu_pins", alsu_pins, (cyc == iss_cyc) ? iss_cmd : CMD_W'(0));
      check("rsp0_valid", bus.rsp0_valid, (cyc == rsp_cyc) && (rsp_own == 0));
      check("rsp1_valid", bus.rsp1_valid, (cyc == rsp_cyc) && (rsp_own == 1));
      if (cyc == rsp_cyc) begin
        check("rsp_data", bus.rsp_data, rsp_dat);
        check("rsp_err", bus.rsp_err, rsp_e);
      end
      if (cyc == zero_cyc) begin
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
      end
    end
    if (!rst) begin
      live     = 1'b1;
      free_cyc = cyc + 1;
      iss_cyc  = -1;
      rsp_cyc  = -1;
      zero_cyc = cyc + 1;
      last_gnt = 1;
    end else if (live && exp_gnt != 2'b00) begin
      own      = exp_gnt[1] ? 1 : 0;
      c        = exp_gnt[1] ? bus.req1_cmd : bus.req0_cmd;
      last_gnt = own;
      rsp_own  = own;
      if (c[OFS_OPCODE +: 3] inside {OPC_INV0, OPC_INV1}) begin
        iss_cyc  = -1;
        rsp_cyc  = cyc + 1;
        rsp_dat  = '0;
        rsp_e    = 1'b1;
        free_cyc = cyc + 2;
      end else begin
        iss_cyc  = cyc + 1;
        iss_cmd  = c;
        rsp_cyc  = cyc + LAT + 2;
        rsp_dat  = alsu_ref(c);
        rsp_e    = 1'b0;
        free_cyc = cyc + LAT + 3;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic logic [CMD_W-1:0] mk_cmd(input logic [2:0] opc, input logic [2:0] a,
                                               input logic [2:0] b, input logic byp_a);
    logic [CMD_W-1:0] c;
    c                 = '0;
    c[OFS_OPCODE +: 3] = opc;
    c[OFS_A +: 3]     = a;
    c[OFS_B +: 3]     = b;
    c[OFS_BYP_A]      = byp_a;
    return c;
  endfunction

  // Random command; shift/rotate are left out since their result depends on ALSU history.
  function automatic logic [CMD_W-1:0] rand_cmd(input bit allow_inv);
    logic [CMD_W-1:0] c;
    logic [2:0]       opc;
    c = CMD_W'($urandom);
    do opc = 3'($urandom_range(0, 7));
    while (opc == OPC_SHIFT || opc == OPC_ROT ||
           (!allow_inv && (opc == OPC_INV0 || opc == OPC_INV1)));
    c[OFS_OPCODE +: 3] = opc;
    if ($urandom_range(0, 3) != 0) begin
      c[OFS_BYP_A] = 1'b0;
      c[OFS_BYP_B] = 1'b0;
    end
    return c;
  endfunction

  // Present one command and hold it until accepted (bounded).
  task automatic send(input int idx, input logic [CMD_W-1:0] c);
    if (idx == 0) begin bus.req0_cmd = c; bus.req0_valid = 1'b1; end
    else          begin bus.req1_cmd = c; bus.req1_valid = 1'b1; end
    for (int n = 0; n < 60; n++) begin
      step();
      if (obs_acc[idx]) break;
    end
    check("grant_seen", obs_acc[idx], 1);
    if (idx == 0) bus.req0_valid = 1'b0;
    else          bus.req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    obs_own.delete();
    obs_at.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] v;
    bit         outst[2];
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_cmd   = '0;
    bus.req1_cmd   = '0;
    repeat (3) step();
    rst = 1'b1;
    step();

    // Reset while the ALSU result is pending: no response must follow.
    send(0, mk_cmd(3'b011, 3'd3, 3'd2, 1'b0));
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (5) step();

    // Single multiply, invalid opcode, bypass passthrough.
    send(0, mk_cmd(3'b011, 3'd3, 3'd2, 1'b0));
    repeat (6) step();
    send(1, mk_cmd(3'b111, 3'd5, 3'd4, 1'b0));
    repeat (3) step();
    send(0, mk_cmd(3'b010, 3'd5, 3'd3, 1'b1));
    repeat (6) step();

    // Both requesters held valid: alternating grants at peak rate.
    do_reset();
    bus.req0_cmd   = rand_cmd(1'b0);
    bus.req1_cmd   = rand_cmd(1'b0);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int n = 0; n < 200 && obs_own.size() < 6; n++) begin
      step();
      if (obs_acc[0]) bus.req0_cmd = rand_cmd(1'b0);
      if (obs_acc[1]) bus.req1_cmd = rand_cmd(1'b0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("fair_grants", obs_own.size(), 6);
    for (int i = 0; i < obs_own.size(); i++) check("fair_owner", obs_own[i], i % 2);
    for (int i = 1; i < obs_at.size(); i++) check("fair_spacing", obs_at[i] - obs_at[i-1], LAT + 3);
    repeat (6) step();

    // Lone requester served back-to-back; a request withdrawn while busy is not served.
    obs_own.delete();
    obs_at.delete();
    bus.req1_cmd   = rand_cmd(1'b0);
    bus.req1_valid = 1'b1;
    for (int n = 0; n < 100 && obs_own.size() < 3; n++) begin
      step();
      bus.req0_cmd   = mk_cmd(3'b001, 3'd6, 3'd1, 1'b0);
      bus.req0_valid = obs_acc[1];
      if (obs_acc[1]) bus.req1_cmd = rand_cmd(1'b0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("solo_grants", obs_own.size(), 3);
    for (int i = 0; i < obs_own.size(); i++) check("solo_owner", obs_own[i], 1);
    for (int i = 1; i < obs_at.size(); i++) check("solo_spacing", obs_at[i] - obs_at[i-1], LAT + 3);
    repeat (6) step();

    // Random requesters with one outstanding command each; a reset midway.
    outst = '{1'b0, 1'b0};
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        do_reset();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        outst = '{1'b0, 1'b0};
      end
      step();
      v = {bus.req1_valid, bus.req0_valid};
      for (int i = 0; i < 2; i++) begin
        if (obs_acc[i]) begin
          v[i]     = 1'b0;
          outst[i] = 1'b1;
        end
        if (obs_rsp[i]) outst[i] = 1'b0;
        if (v[i] && $urandom_range(0, 31) == 0) begin
          v[i] = 1'b0;
        end else if (!v[i] && !outst[i] && $urandom_range(0, 2) == 0) begin
          v[i] = 1'b1;
          if (i == 0) bus.req0_cmd = rand_cmd(1'b1);
          else        bus.req1_cmd = rand_cmd(1'b1);
        end
      end
      bus.req0_valid = v[0];
      bus.req1_valid = v[1];
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
